pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have ports, in this order (name  direction  width  meaning):
- clk_100MHz  in  1  system clock; all state updates on its rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- hold_ena_i  in  1  pipeline stall; the downstream stage does not consume this cycle.
- jump_ena_i  in  1  redirect request from execute.
- jump_addr_i  in  32  redirect target.
- ibus_req_o  out  1  fetch request valid.
- ibus_addr_o  out  32  fetch address, word aligned.
- ibus_gnt_i  in  1  request accepted this cycle.
- ibus_rvalid_i  in  1  read data valid.
- ibus_rdata_i  in  32  instruction word.
- inst_o  out  32  instruction to the decode-stage register.
- inst_addr_o  out  32  address of inst_o.
- inst_valid_o  out  1  inst_o/inst_addr_o hold a real instruction.
REQ-002 SHALL use reset arst_n, asynchronous, active-low, and clock clk_100MHz.
REQ-003 SHALL take CPU_RESET_ADDR = 32'h0000_0000 as the reset fetch address; the bubble value SHALL be 32'h0000_0000.

Function
REQ-004 SHALL hold the fetch PC register pc_q; ibus_addr_o = pc_q with bits[1:0] = 0.
REQ-005 SHALL treat a request as accepted on any cycle where ibus_req_o=1 and ibus_gnt_i=1; pc_q SHALL then advance by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-006 SHALL hold ibus_addr_o stable while ibus_req_o=1 and ibus_gnt_i=0, unless a jump occurs.
REQ-007 SHALL take responses in order, at least 1 cycle after the grant; an rvalid that arrives while nothing is outstanding is ignored.
REQ-008 SHALL track outstanding requests (granted, no rvalid yet) with a counter, and buffered instructions in a FIFO of depth CAP; CAP is set by REQ-019.
REQ-009 SHALL assert ibus_req_o only when outstanding + buffered < CAP and jump_ena_i=0.
REQ-010 SHALL store each accepted response in the FIFO together with its fetch address.
REQ-011 SHALL drive the outputs combinationally from the FIFO head:
- FIFO non-empty: inst_valid_o=1, inst_o/inst_addr_o = the head entry.
- FIFO empty: inst_valid_o=0, inst_o = inst_addr_o = bubble.
REQ-012 SHALL pop the head when inst_valid_o=1, hold_ena_i=0 and jump_ena_i=0.
- A push and a pop in the same cycle are both legal; occupancy is unchanged.
REQ-013 On jump_ena_i=1, SHALL take all of the following actions, and jump SHALL take priority over hold:
- Load pc_q with {jump_addr_i[31:2], 2'b00}.
- Flush the FIFO.
- Move the outstanding count into a discard counter.
- Drop the request of that cycle; any grant in that cycle SHALL not change the PC or the counters.
REQ-014 SHALL drop every rvalid while the discard counter is non-zero, decrementing it; new requests SHALL obey REQ-009 with discarded responses counted as outstanding.
REQ-015 A second jump while discarding SHALL add the current outstanding count to the discard count.
REQ-016 hold_ena_i alone SHALL NOT stop fetching; requests continue until the FIFO fills, and no entry is lost or duplicated.

Reset
REQ-017 While arst_n=0, SHALL set:
- pc_q = CPU_RESET_ADDR.
- FIFO empty; outstanding and discard counters = 0.
- ibus_req_o=0, inst_valid_o=0, inst_o = inst_addr_o = 0.
REQ-018 SHALL raise its first request to address 0 on the first clock edge after arst_n is released; the instruction bus is reset by the same arst_n, so no pre-reset responses remain.

Configuration
REQ-019 Macro FETCH_BUF_EN:
- Defined: CAP=2 (two-entry FIFO, up to 2 outstanding), giving one instruction per cycle when the bus has 1-cycle latency.
- Undefined: CAP=1 (single-entry holding register, one outstanding request), at most one instruction every 2 cycles.
- All other requirements are identical in both builds.

Verification
REQ-020 Reset release, ibus_gnt_i tied 1, rvalid 1 cycle after the grant with rdata = addr^32'hA5A5_0000 -> inst_addr_o sequence 0,4,8,C with matching inst_o; 1 instruction/cycle with FETCH_BUF_EN, 1 every 2 cycles without.
REQ-021 hold_ena_i=1 for 5 cycles mid-stream -> inst_o frozen, ibus_req_o drops after CAP entries, no address skipped or repeated after hold release.
REQ-022 jump_ena_i=1, jump_addr_i=32'h0000_0103, with 2 requests in flight -> both stale responses dropped, next inst_addr_o = 32'h0000_0100.
REQ-023 jump_ena_i=1 and hold_ena_i=1 in the same cycle -> redirect taken, FIFO flushed, inst_valid_o=0 next cycle.
REQ-024 pc_q = 32'hFFFF_FFFC granted -> next ibus_addr_o = 32'h0000_0000; arst_n pulsed low mid-burst -> all outputs 0 immediately, fetch restarts at 0.

Source files
------------

// File: rtl/pc_fetch.sv
// +--------------------------------------------------------------------------+
// | pc_fetch : instruction fetch unit with an in-order response buffer,     |
// |            stall handling and redirect with stale-response discard.     |
// | Build option: FETCH_BUF_EN (two-entry buffer, two requests in flight).  |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_fetch (
   input  logic        clk_100MHz,
   input  logic        arst_n,
   input  logic        hold_ena_i,
   input  logic        jump_ena_i,
   input  logic [31:0] jump_addr_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);

   localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;
   localparam logic [31:0] BUBBLE         = 32'h0000_0000;
   localparam logic [31:0] ALIGN_MASK     = 32'hFFFF_FFFC;
`ifdef FETCH_BUF_EN
   localparam int          CAP            = 2;
`else
   localparam int          CAP            = 1;
`endif
   localparam logic [2:0]  CAP_LIMIT      = 3'(CAP);

   logic        r_run;
   logic [31:0] r_pc;
   logic [31:0] r_rsp_addr;
   logic [1:0]  r_outstanding;
   logic [1:0]  r_discard;
   logic [1:0]  r_count;
   logic [31:0] r_buf_inst [CAP];
   logic [31:0] r_buf_addr [CAP];

   logic [31:0] w_shift_inst [CAP];
   logic [31:0] w_shift_addr [CAP];
   logic [31:0] w_jump_target;
   logic        w_accept;
   logic        w_rsp_drop;
   logic        w_rsp_good;
   logic        w_push;
   logic        w_pop;
   logic [2:0]  w_used;
   logic [1:0]  w_wr_idx;

   assign w_jump_target = jump_addr_i & ALIGN_MASK;
   assign w_pop         = (r_count != 2'd0) && !hold_ena_i && !jump_ena_i;
   assign w_rsp_drop    = ibus_rvalid_i && (r_discard != 2'd0);
   assign w_rsp_good    = ibus_rvalid_i && (r_discard == 2'd0) && (r_outstanding != 2'd0);
   assign w_push        = w_rsp_good && !jump_ena_i;

   // An entry leaving the buffer this cycle frees its slot for a new request
   assign w_used = {1'b0, r_outstanding} + {1'b0, r_discard} + {1'b0, r_count}
                 - {2'b00, w_pop};

   assign ibus_req_o  = r_run && !jump_ena_i && (w_used < CAP_LIMIT);
   assign ibus_addr_o = r_pc & ALIGN_MASK;
   assign w_accept    = ibus_req_o && ibus_gnt_i;
   assign w_wr_idx    = r_count - {1'b0, w_pop};

   assign inst_valid_o = (r_count != 2'd0);
   assign inst_o       = inst_valid_o ? r_buf_inst[0] : BUBBLE;
   assign inst_addr_o  = inst_valid_o ? r_buf_addr[0] : BUBBLE;

   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         r_run         <= 1'b0;
         r_pc          <= CPU_RESET_ADDR;
         r_rsp_addr    <= CPU_RESET_ADDR;
         r_outstanding <= 2'd0;
         r_discard     <= 2'd0;
         r_count       <= 2'd0;
      end else begin
         r_run <= 1'b1;
         if (jump_ena_i) begin
            // Requests still in flight become discards; a response this cycle retires one
            r_pc          <= w_jump_target;
            r_rsp_addr    <= w_jump_target;
            r_outstanding <= 2'd0;
            r_discard     <= r_discard - {1'b0, w_rsp_drop} + r_outstanding
                           - {1'b0, w_rsp_good};
            r_count       <= 2'd0;
         end else begin
            r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_rsp_good};
            r_discard     <= r_discard - {1'b0, w_rsp_drop};
            r_count       <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_accept) begin
               r_pc <= r_pc + 32'd4;
            end
            if (w_rsp_good) begin
               r_rsp_addr <= r_rsp_addr + 32'd4;
            end
         end
      end
   end

   for (genvar gi = 0; gi < CAP; gi++) begin : g_shift
      if (gi + 1 < CAP) begin : g_mid
         assign w_shift_inst[gi] = r_buf_inst[gi+1];
         assign w_shift_addr[gi] = r_buf_addr[gi+1];
      end else begin : g_tail
         assign w_shift_inst[gi] = r_buf_inst[gi];
         assign w_shift_addr[gi] = r_buf_addr[gi];
      end
   end

   // Head is always entry 0; a same-cycle push lands behind the shifted entries
   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < CAP; i++) begin
            r_buf_inst[i] <= BUBBLE;
            r_buf_addr[i] <= BUBBLE;
         end
      end else if (!jump_ena_i) begin
         for (int i = 0; i < CAP; i++) begin
            if (w_push && (w_wr_idx == 2'(i))) begin
               r_buf_inst[i] <= ibus_rdata_i;
               r_buf_addr[i] <= r_rsp_addr;
            end else if (w_pop) begin
               r_buf_inst[i] <= w_shift_inst[i];
               r_buf_addr[i] <= w_shift_addr[i];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_pc_fetch : directed self-checking bench for pc_fetch with an in-order |
// |               fixed-latency instruction bus responder.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_BUF_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk_100MHz;
   logic        arst_n;
   logic        hold_ena_i;
   logic        jump_ena_i;
   logic [31:0] jump_addr_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;

   pc_fetch dut (
      .clk_100MHz    (clk_100MHz),
      .arst_n        (arst_n),
      .hold_ena_i    (hold_ena_i),
      .jump_ena_i    (jump_ena_i),
      .jump_addr_i   (jump_addr_i),
      .ibus_req_o    (ibus_req_o),
      .ibus_addr_o   (ibus_addr_o),
      .ibus_gnt_i    (ibus_gnt_i),
      .ibus_rvalid_i (ibus_rvalid_i),
      .ibus_rdata_i  (ibus_rdata_i),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o),
      .inst_valid_o  (inst_valid_o)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          lat      = 1;
   logic [31:0] q_addr [$];
   int          q_due  [$];
   logic [31:0] exp_head;
   logic        s_req;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_inst;
   logic [31:0] s_iaddr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, sample 1 ns later, then cross the rising edge
   task automatic cycle(input logic h, input logic j, input logic [31:0] ja);
      hold_ena_i  = h;
      jump_ena_i  = j;
      jump_addr_i = ja;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = q_addr[0] ^ KEY;
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end else begin
         ibus_rvalid_i = 1'b0;
         ibus_rdata_i  = 32'hDEAD_BEEF;
      end
      #1;
      s_req   = ibus_req_o;
      s_addr  = ibus_addr_o;
      s_valid = inst_valid_o;
      s_inst  = inst_o;
      s_iaddr = inst_addr_o;
      if (s_valid) begin
         check_eq("head_addr", s_iaddr, exp_head);
         check_eq("head_inst", s_inst, exp_head ^ KEY);
      end
      if (s_valid && !h && !j) exp_head = exp_head + 32'd4;
      if (j) exp_head = ja & 32'hFFFF_FFFC;
      if (s_req && ibus_gnt_i) begin
         q_addr.push_back(s_addr);
         q_due.push_back(cyc + lat);
      end
      @(posedge clk_100MHz);
      cyc++;
      @(negedge clk_100MHz);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_req"},   {31'd0, ibus_req_o},   32'd0);
      check_eq({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
      check_eq({tag, "_inst"},  inst_o,                32'd0);
      check_eq({tag, "_iaddr"}, inst_addr_o,           32'd0);
      check_eq({tag, "_addr"},  ibus_addr_o,           32'd0);
   endtask

   initial begin
      logic [31:0] held;
      logic        exp_v;
      logic        prev_fffc;
      int          wrap_seen;
      int          waited;

      arst_n        = 1'b0;
      hold_ena_i    = 1'b0;
      jump_ena_i    = 1'b0;
      jump_addr_i   = 32'd0;
      ibus_gnt_i    = 1'b1;
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = 32'd0;
      exp_head      = 32'd0;

      // Reset state
      @(negedge clk_100MHz);
      @(negedge clk_100MHz);
      #1;
      check_all_zero("reset");
      @(negedge clk_100MHz);
      arst_n = 1'b1;
      #1;
      check_eq("req_before_edge", {31'd0, ibus_req_o}, 32'd0);
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);

      // Streaming at 1-cycle latency
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b0, 1'b0, 32'd0);
         if (k == 1) begin
            check_eq("first_req", {31'd0, s_req}, 32'd1);
            check_eq("first_addr", s_addr, 32'd0);
         end
         exp_v = (k >= 3) && ((CAP == 2) || (((k - 3) % 2) == 0));
         check_eq("stream_valid", {31'd0, s_valid}, {31'd0, exp_v});
      end

      // Stall for 5 cycles: head frozen, fetching stops once the buffer is full
      held = exp_head;
      for (int h = 0; h < 5; h++) begin
         cycle(1'b1, 1'b0, 32'd0);
         check_eq("hold_valid", {31'd0, s_valid}, 32'd1);
         check_eq("hold_frozen", s_iaddr, held);
      end
      check_eq("hold_req_drop", {31'd0, s_req}, 32'd0);
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'd0);

      // Redirect with requests in flight on a slower bus
      lat    = 3;
      waited = 0;
      while (q_addr.size() < CAP && waited < 20) begin
         cycle(1'b0, 1'b0, 32'd0);
         waited++;
      end
      check_eq("inflight", q_addr.size(), CAP);
      cycle(1'b0, 1'b1, 32'h0000_0103);
      check_eq("jump_req_drop", {31'd0, s_req}, 32'd0);
      cycle(1'b0, 1'b0, 32'd0);
      check_eq("jump_flush_valid", {31'd0, s_valid}, 32'd0);
      check_eq("jump_pc", s_addr, 32'h0000_0100);
      waited = 0;
      while (!s_valid && waited < 20) begin
         cycle(1'b0, 1'b0, 32'd0);
         waited++;
      end
      check_eq("jump_first_addr", s_iaddr, 32'h0000_0100);
      check_eq("jump_first_inst", s_inst, 32'hA5A5_0100);
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'd0);

      // Redirect and stall together
      lat = 1;
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 32'h0000_0200);
      cycle(1'b0, 1'b0, 32'd0);
      check_eq("jh_flush_valid", {31'd0, s_valid}, 32'd0);
      check_eq("jh_pc", s_addr, 32'h0000_0200);
      waited = 0;
      while (!s_valid && waited < 20) begin
         cycle(1'b0, 1'b0, 32'd0);
         waited++;
      end
      check_eq("jh_first_addr", s_iaddr, 32'h0000_0200);

      // PC wrap from the top of the address space
      cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
      prev_fffc = 1'b0;
      wrap_seen = 0;
      for (int k = 0; k < 12; k++) begin
         cycle(1'b0, 1'b0, 32'd0);
         if (prev_fffc) begin
            check_eq("wrap_addr", s_addr, 32'd0);
            wrap_seen++;
         end
         prev_fffc = s_req && ibus_gnt_i && (s_addr == 32'hFFFF_FFFC);
      end
      check_eq("wrap_seen", {31'd0, wrap_seen != 0}, 32'd1);

      // Asynchronous reset mid-burst
      arst_n = 1'b0;
      #1;
      check_all_zero("arst");
      q_addr.delete();
      q_due.delete();
      exp_head      = 32'd0;
      ibus_rvalid_i = 1'b0;
      @(negedge clk_100MHz);
      arst_n = 1'b1;
      #1;
      check_eq("rerun_req_before_edge", {31'd0, ibus_req_o}, 32'd0);
      @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b0, 1'b0, 32'd0);
         if (k == 1) begin
            check_eq("rerun_req", {31'd0, s_req}, 32'd1);
            check_eq("rerun_addr", s_addr, 32'd0);
         end
         if (k == 3) check_eq("rerun_valid", {31'd0, s_valid}, 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
